// File: rtl/fetch_buffer_pkg.sv
// Shared fetch/decode core definitions: field widths, the decode bubble
// instruction and the {pc, instr} queue entry layout.
package fetch_buffer_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [1:0] pc_lsbs);
        return pc_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Instruction fetch queue between the pc/instr_rom pair and decode: a small
// circular FIFO of {pc, instr} entries with valid/ready on both sides.
module fetch_buffer
    import fetch_buffer_pkg::is_word_aligned;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = fetch_buffer_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic [XLEN-1:0]          fetch_instr,
    output logic                     fetch_ready,
    input  logic                     flush,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [XLEN-1:0]          dec_pc,
    output logic [XLEN-1:0]          dec_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     misalign_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            aligned;
    logic            push;
    logic            pop;
    logic            misalign_attempt;

    // Ready depends only on the registered count; no pop-to-ready bypass.
    assign fetch_ready      = (count < CW'(DEPTH));
    assign dec_valid        = (count != '0);
    assign aligned          = is_word_aligned(fetch_pc[1:0]);
    assign push             = fetch_valid & fetch_ready & ~flush & aligned;
    assign pop              = dec_valid & dec_ready & ~flush;
    assign misalign_attempt = fetch_valid & fetch_ready & ~flush & ~aligned;

    assign dec_pc    = dec_valid ? mem[rd_ptr].pc    : '0;
    assign dec_instr = dec_valid ? mem[rd_ptr].instr : '0;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (misalign_attempt) begin
                misalign_err <= 1'b1;
            end
        end
    end

    // Storage is deliberately left uncleared by reset and flush.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= '{pc: fetch_pc, instr: fetch_instr};
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a negedge monitor keeps a reference
// queue and occupancy model; scenario tasks add targeted inline checks.
module tb_fetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            fetch_valid = 1'b0;
    logic [XLEN-1:0] fetch_pc = '0;
    logic [XLEN-1:0] fetch_instr = '0;
    logic            fetch_ready;
    logic            flush = 1'b0;
    logic            dec_valid;
    logic            dec_ready = 1'b0;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_instr;
    logic [CW-1:0]   count;
    logic            misalign_err;

    int vectors = 0;
    int miscompares = 0;

    logic [2*XLEN-1:0] sb_q[$];
    int unsigned       m_count = 0;
    logic              m_mis = 1'b0;
    logic              armed = 1'b0;

    fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .fetch_ready(fetch_ready), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_instr(dec_instr),
        .count(count), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Reference model: inputs change at posedge+1, so negedge sees them stable.
    always @(negedge clk) begin
        logic              m_push;
        logic              m_pop;
        logic [2*XLEN-1:0] head;
        if (reset) begin
            sb_q.delete();
            m_count = 0;
            m_mis   = 1'b0;
            armed   = 1'b1;
        end else if (armed) begin
            vectors++;
            if (count !== CW'(m_count) || dec_valid !== (m_count != 0) ||
                fetch_ready !== (m_count < DEPTH) || misalign_err !== m_mis) begin
                miscompares++;
                $display("FAIL mon_status t=%0t count=%0d/%0d dec_valid=%b fetch_ready=%b misalign=%b/%b",
                         $time, count, m_count, dec_valid, fetch_ready, misalign_err, m_mis);
            end
            head = (sb_q.size() != 0) ? sb_q[0] : '0;
            vectors++;
            if ({dec_pc, dec_instr} !== head) begin
                miscompares++;
                $display("FAIL mon_head t=%0t got pc=%h instr=%h expected pc=%h instr=%h",
                         $time, dec_pc, dec_instr, head[2*XLEN-1:XLEN], head[XLEN-1:0]);
            end
            m_push = fetch_valid && (m_count < DEPTH) && !flush && (fetch_pc[1:0] == 2'b00);
            m_pop  = (m_count != 0) && dec_ready && !flush;
            if (flush) begin
                sb_q.delete();
                m_count = 0;
                m_mis   = 1'b0;
            end else begin
                if (fetch_valid && (m_count < DEPTH) && fetch_pc[1:0] != 2'b00) m_mis = 1'b1;
                if (m_pop) void'(sb_q.pop_front());
                if (m_push) sb_q.push_back({fetch_pc, fetch_instr});
                m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                         input logic rdy, input logic fl);
        fetch_valid = v;
        fetch_pc    = pc;
        fetch_instr = ins;
        dec_ready   = rdy;
        flush       = fl;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (count !== '0 || dec_valid !== 1'b0 || fetch_ready !== 1'b1 || misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state count=%0d dec_valid=%b fetch_ready=%b misalign=%b expected 0 0 1 0",
                     count, dec_valid, fetch_ready, misalign_err);
        end
    endtask

    task automatic test_in_order();
        logic [XLEN-1:0] ins [3];
        ins[0] = 32'h00500093;
        ins[1] = 32'h00100113;
        ins[2] = 32'h002081B3;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, XLEN'(4 * i), ins[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (count !== CW'(3) || dec_pc !== 32'h0 || dec_instr !== 32'h00500093) begin
                miscompares++;
                $display("FAIL in_order_hold count=%0d pc=%h instr=%h expected 3 00000000 00500093",
                         count, dec_pc, dec_instr);
            end
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if (count !== '0 || dec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL in_order_drain count=%0d dec_valid=%b expected 0 0", count, dec_valid);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + XLEN'(4 * i), 32'hA000_0000 + XLEN'(i), 1'b0, 1'b0);
            tick();
        end
        vectors++;
        if (count !== CW'(4) || fetch_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_state count=%0d fetch_ready=%b expected 4 0", count, fetch_ready);
        end
        drive(1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        vectors++;
        if (count !== CW'(4)) begin
            miscompares++;
            $display("FAIL full_reject count=%0d expected 4", count);
        end
        drive(1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        vectors++;
        if (count !== CW'(3) || fetch_ready !== 1'b1 || dec_pc !== 32'h14) begin
            miscompares++;
            $display("FAIL full_pop count=%0d fetch_ready=%b pc=%h expected 3 1 00000014",
                     count, fetch_ready, dec_pc);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (4) tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        vectors++;
        if (count !== '0) begin
            miscompares++;
            $display("FAIL full_empty_pop count=%0d expected 0", count);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h0, 32'hB000_0000, 1'b0, 1'b0);
        tick();
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, XLEN'(4 * i), 32'hB000_0000 + XLEN'(i), 1'b1, 1'b0);
            tick();
            vectors++;
            if (count !== CW'(1) || dec_pc !== XLEN'(4 * i)) begin
                miscompares++;
                $display("FAIL b2b_step%0d count=%0d pc=%h expected 1 %h", i, count, dec_pc, 4 * i);
            end
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + XLEN'(4 * i), 32'hC000_0000 + XLEN'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h40, 32'hC000_0040, 1'b1, 1'b1);
        tick();
        vectors++;
        if (count !== '0 || dec_valid !== 1'b0 || dec_pc !== '0) begin
            miscompares++;
            $display("FAIL flush_clear count=%0d dec_valid=%b pc=%h expected 0 0 0", count, dec_valid, dec_pc);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (count !== '0) begin
            miscompares++;
            $display("FAIL flush_drop count=%0d expected 0", count);
        end
    endtask

    task automatic test_misalign();
        drive(1'b1, 32'h200, 32'hD000_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h6, 32'hD000_0006, 1'b0, 1'b0);
        tick();
        vectors++;
        if (count !== CW'(1) || misalign_err !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_set count=%0d misalign=%b expected 1 1", count, misalign_err);
        end
        drive(1'b1, 32'h204, 32'hD000_0204, 1'b0, 1'b0);
        tick();
        vectors++;
        if (count !== CW'(2) || misalign_err !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_sticky count=%0d misalign=%b expected 2 1", count, misalign_err);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        vectors++;
        if (count !== '0 || misalign_err !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_clear count=%0d misalign=%b expected 0 0", count, misalign_err);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_back_to_back();
        test_flush();
        test_misalign();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch queue directly downstream of the pc register and instr_rom pair.
- Each cycle it captures the {pc, instruction} pair presented by fetch and holds it in a small FIFO.
- It presents the oldest entry to decode over a valid/ready handshake.
- It back-pressures the PC via fetch_ready, which drives pc_write_enable, and discards everything on a redirect flush.

Parameters:
- DEPTH, 4, number of queue entries; power of two, DEPTH >= 2.
- XLEN, 32, width of the pc and instruction fields.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_valid  input  1  fetch_pc/fetch_instr hold a valid pair this cycle.
- fetch_pc  input  XLEN  address of the fetched instruction (the pc_current value).
- fetch_instr  input  XLEN  instruction word from instr_rom for fetch_pc.
- fetch_ready  output  1  queue can accept a pair; drives pc_write_enable.
- flush  input  1  redirect (branch/jump); empties the queue.
- dec_valid  output  1  head entry is valid for decode.
- dec_ready  input  1  decode consumes the head entry this cycle.
- dec_pc  output  XLEN  pc of the head entry.
- dec_instr  output  XLEN  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  current number of entries.
- misalign_err  output  1  sticky flag: a push with fetch_pc[1:0] != 0 was attempted.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on port reset; it is sampled only at the rising edge of clk.
- Reset state (reset high at an edge):
  - Read pointer, write pointer and count = 0.
  - dec_valid = 0, misalign_err = 0, fetch_ready = 1 from the following cycle.
  - Entry storage is not cleared.
- Storage and pointers:
  - Circular buffer of DEPTH entries, each {pc, instr}.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count is tracked separately to distinguish full from empty.
- Combinational outputs:
  - fetch_ready = (count < DEPTH). It uses only the registered count; there is no same-cycle pop-to-ready bypass.
  - dec_valid = (count != 0).
  - dec_pc/dec_instr = entry at the read pointer when dec_valid = 1. When empty, both are forced to 0.
- Push and pop:
  - push = fetch_valid & fetch_ready & ~flush & (fetch_pc[1:0] == 0).
  - pop = dec_valid & dec_ready & ~flush.
  - Push writes at the write pointer, then increments it. Pop increments the read pointer.
  - count' = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Latency:
  - A pair pushed at edge N is visible on dec_* after edge N (1 cycle).
  - There is no fall-through bypass when the queue is empty.
- Flush:
  - At the edge where flush = 1, both pointers and count go to 0 and misalign_err clears.
  - Any fetch pair and any dec_ready in that cycle are ignored.
- Misalignment:
  - fetch_valid & fetch_ready & (fetch_pc[1:0] != 0) with no flush: the pair is dropped and misalign_err is set.
  - misalign_err stays set until flush or reset.
- Boundary cases:
  - Full with dec_ready = 1: the pop occurs, no push that cycle, and fetch_ready rises the next cycle.
  - Empty with dec_ready = 1: no effect.
  - Pointer wrap from DEPTH-1 to 0 must preserve FIFO order.
  - Reset has priority over flush; flush has priority over push and pop.
- Stability: dec_pc/dec_instr must hold stable while dec_valid = 1 and dec_ready = 0.

Decomposition:
- Shared core package:
  - XLEN.
  - NOP_INSTR = 32'h00000013, for the later decode bubble.
  - A packed fetch_entry typedef {pc, instr}.
- No sub-module: the storage array, pointers and count live in this one module.
- The pc and instr_rom instances stay outside; top-level glue wires fetch_ready to pc_write_enable.

Test Plan:
1. Reset high 2 cycles, then low -> count=0, dec_valid=0, fetch_ready=1, misalign_err=0.
2. Push pc=0,4,8 with instr 0x00500093, 0x00100113, 0x002081B3, dec_ready=0 -> count=3, dec_pc=0, dec_instr=0x00500093 stable. Then dec_ready=1 for 3 cycles -> pairs emerge in order, count returns to 0.
3. Push 4 pairs with dec_ready=0 -> count=4, fetch_ready=0; a 5th fetch_valid is not accepted. Then one dec_ready pulse -> count=3, fetch_ready=1 the next cycle.
4. Continuous push and pop for 10 cycles at pc=0x00..0x24 -> count steady at 1, pointers wrap past 3, and the output order matches the input order.
5. Queue holds 3 entries; assert flush with fetch_valid=1, pc=0x40 -> next cycle count=0, dec_valid=0. The pc=0x40 pair is not stored.
6. Push fetch_pc=0x6 -> not stored, count unchanged, misalign_err=1. It persists through normal pushes and clears after flush.
